// File: rtl/snake_pkg.sv
// Shared encodings and colour constants for the snake engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_MOVE,
    ST_CHECK,
    ST_DEAD
  } state_t;

  localparam logic [11:0] COL_HEAD      = 12'hFF0;
  localparam logic [11:0] COL_DEAD_HEAD = 12'hF0F;
  localparam logic [11:0] COL_BODY      = 12'h0F0;
  localparam logic [11:0] COL_FOOD      = 12'hF00;
  localparam logic [11:0] COL_BG        = 12'h000;

  // Opposite directions differ only in the upper encoding bit.
  function automatic dir_t reverse_of(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_engine_counter.sv
// Free-running modulo counter with a terminal-count trigger; used as the move tick timer.
module Generic_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE_IN,
  output logic TRIG_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] CMAX = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (ENABLE_IN) begin
      if (r_count == CMAX) r_count <= '0;
      else                 r_count <= r_count + 1'b1;
    end
  end

  assign TRIG_OUT = ENABLE_IN && (r_count == CMAX);

endmodule

// File: rtl/snake_engine.sv
// Variable-length snake: segment storage, movement FSM, self-collision and pixel rendering.
module snake_engine
  import snake_pkg::*;
#(
  parameter int MAX_LENGTH  = 32,
  parameter int INIT_LENGTH = 4,
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int MOVE_PERIOD = 3000000,
  parameter int START_X     = 80,
  parameter int START_Y     = 100,
  localparam int LW         = $clog2(MAX_LENGTH + 1)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           ENABLE,
  input  logic [1:0]     NAV_STATE,
  input  logic [X_W-1:0] FOOD_X,
  input  logic [Y_W-1:0] FOOD_Y,
  input  logic [9:0]     ADDRH,
  input  logic [8:0]     ADDRV,
  output logic [11:0]    COLOUR_OUT,
  output logic           FOOD_EATEN,
  output logic           COLLISION,
  output logic [LW-1:0]  LENGTH
);

  localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  function automatic logic [X_W-1:0] init_x(input int i);
    int v;
    v = (START_X - i) % GRID_W;
    if (v < 0) v += GRID_W;
    return X_W'(v);
  endfunction

  state_t         r_state;
  dir_t           r_dir;
  logic [X_W-1:0] r_seg_x [MAX_LENGTH];
  logic [Y_W-1:0] r_seg_y [MAX_LENGTH];
  logic [LW-1:0]  r_length;
  logic           r_food_eaten;
  logic           r_collision;

  logic           w_tick_rst, w_trig, w_tick;
  dir_t           w_new_dir;
  logic [X_W-1:0] w_head_x, w_pix_x;
  logic [Y_W-1:0] w_head_y, w_pix_y;
  logic           w_self_hit, w_food_hit;
  logic           w_pix_head, w_pix_body, w_pix_food;
  logic           w_unused_addr_lsbs;

  assign w_tick_rst = RESET || (r_state != ST_RUN);

  Generic_counter #(
    .COUNTER_WIDTH(TW),
    .COUNTER_MAX  (MOVE_PERIOD - 1)
  ) u_tick (
    .CLK      (CLK),
    .RESET    (w_tick_rst),
    .ENABLE_IN(1'b1),
    .TRIG_OUT (w_trig)
  );

  assign w_tick    = w_trig && (r_state == ST_RUN);
  assign w_new_dir = (dir_t'(NAV_STATE) == reverse_of(r_dir)) ? r_dir : dir_t'(NAV_STATE);

  always_comb begin
    w_head_x = r_seg_x[0];
    w_head_y = r_seg_y[0];
    unique case (w_new_dir)
      DIR_UP:    w_head_y = (r_seg_y[0] == '0) ? Y_W'(GRID_H - 1) : r_seg_y[0] - 1'b1;
      DIR_DOWN:  w_head_y = (r_seg_y[0] == Y_W'(GRID_H - 1)) ? '0 : r_seg_y[0] + 1'b1;
      DIR_LEFT:  w_head_x = (r_seg_x[0] == '0) ? X_W'(GRID_W - 1) : r_seg_x[0] - 1'b1;
      DIR_RIGHT: w_head_x = (r_seg_x[0] == X_W'(GRID_W - 1)) ? '0 : r_seg_x[0] + 1'b1;
    endcase
  end

  assign w_pix_x            = X_W'(ADDRH[9:2]);
  assign w_pix_y            = Y_W'(ADDRV[8:2]);
  assign w_unused_addr_lsbs = ^{ADDRH[1:0], ADDRV[1:0]};

  always_comb begin
    w_self_hit = 1'b0;
    w_pix_body = 1'b0;
    for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
      if (LW'(i) < r_length) begin
        if (r_seg_x[i] == r_seg_x[0] && r_seg_y[i] == r_seg_y[0]) w_self_hit = 1'b1;
        if (r_seg_x[i] == w_pix_x && r_seg_y[i] == w_pix_y)       w_pix_body = 1'b1;
      end
    end
  end

  assign w_food_hit = (r_seg_x[0] == FOOD_X) && (r_seg_y[0] == FOOD_Y);
  assign w_pix_head = (r_seg_x[0] == w_pix_x) && (r_seg_y[0] == w_pix_y);
  assign w_pix_food = (FOOD_X == w_pix_x) && (FOOD_Y == w_pix_y);

  always_comb begin
    if (w_pix_head)      COLOUR_OUT = (r_state == ST_DEAD) ? COL_DEAD_HEAD : COL_HEAD;
    else if (w_pix_body) COLOUR_OUT = COL_BODY;
    else if (w_pix_food) COLOUR_OUT = COL_FOOD;
    else                 COLOUR_OUT = COL_BG;
  end

  // The move happens on the edge into MOVE and the checks on the edge leaving it,
  // so results are visible two cycles after the tick.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_dir        <= DIR_RIGHT;
      r_length     <= LW'(INIT_LENGTH);
      r_food_eaten <= 1'b0;
      r_collision  <= 1'b0;
      for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
        r_seg_x[i] <= init_x(int'(i));
        r_seg_y[i] <= Y_W'(START_Y);
      end
    end else begin
      r_food_eaten <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (ENABLE) r_state <= ST_RUN;
        ST_RUN: begin
          if (!ENABLE) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_dir <= w_new_dir;
            for (int unsigned i = 1; i < MAX_LENGTH; i++) begin
              r_seg_x[i] <= r_seg_x[i-1];
              r_seg_y[i] <= r_seg_y[i-1];
            end
            r_seg_x[0] <= w_head_x;
            r_seg_y[0] <= w_head_y;
            r_state    <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (w_self_hit) begin
            r_collision <= 1'b1;
            r_state     <= ST_DEAD;
          end else begin
            if (w_food_hit) begin
              r_food_eaten <= 1'b1;
              if (r_length != LW'(MAX_LENGTH)) r_length <= r_length + 1'b1;
            end
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: r_state <= ST_RUN;
        ST_DEAD:  r_state <= ST_DEAD;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign FOOD_EATEN = r_food_eaten;
  assign COLLISION  = r_collision;
  assign LENGTH     = r_length;

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised successor to the fixed-length snake controller.
- Keeps a variable-length snake (grows on eating, up to MAX_LENGTH) and blocks 180° reversals.
- Detects self-collision and latches a DEAD state.
- Renders head/body/food colours for the VGA pixel address. Sits between the navigation/master state machines and the VGA colour mux.

Parameters:
- MAX_LENGTH, 32, segment storage depth (≥ INIT_LENGTH, ≥ 2)
- INIT_LENGTH, 4, length after reset
- GRID_W, 160, horizontal cells; X wraps 0..GRID_W-1
- GRID_H, 120, vertical cells; Y wraps 0..GRID_H-1
- X_W, 8, X coordinate width
- Y_W, 7, Y coordinate width
- MOVE_PERIOD, 3000000, CLK cycles per move step
- START_X, 80, initial head X
- START_Y, 100, initial head Y

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  high while the master state is PLAY
- NAV_STATE  in  2  requested direction: UP=00, RIGHT=01, DOWN=10, LEFT=11
- FOOD_X  in  X_W  food cell X
- FOOD_Y  in  Y_W  food cell Y
- ADDRH  in  10  VGA pixel X; cell = ADDRH[9:2]
- ADDRV  in  9  VGA pixel Y; cell = ADDRV[8:2]
- COLOUR_OUT  out  12  pixel colour, combinational
- FOOD_EATEN  out  1  one-cycle pulse per food eaten
- COLLISION  out  1  sticky; high in DEAD
- LENGTH  out  $clog2(MAX_LENGTH+1)  current snake length

Behaviour:
- Reset state:
  - Segment i (0..MAX_LENGTH-1) = ((START_X - i) mod GRID_W, START_Y).
  - Current direction RIGHT; LENGTH = INIT_LENGTH; FOOD_EATEN = 0; COLLISION = 0; state IDLE.
  - RESET in any state, mid-step included, restores all of the above on the next edge.
- States:
  - IDLE: ENABLE high moves to RUN.
  - RUN: tick timer counts. ENABLE low returns to IDLE (pause; positions, length and direction held). Tick moves to MOVE.
  - MOVE: one cycle, then CHECK.
  - CHECK: one cycle, then RUN.
  - DEAD: absorbing; only RESET exits; ENABLE ignored.
- Tick:
  - Timer counts only in RUN; it clears to 0 outside RUN.
  - Tick asserts on the cycle the count equals MOVE_PERIOD-1; the count then wraps to 0.
- MOVE edge:
  - Direction update: current direction ← NAV_STATE, unless NAV_STATE is the exact reverse of the current direction, in which case the current direction is kept.
  - Body shift: all segments i ≥ 1 take segment i-1, across full storage, so segment LENGTH holds the old tail.
  - Head update: head steps one cell in the new direction with wrap. X=0 going LEFT gives GRID_W-1; X=GRID_W-1 going RIGHT gives 0; same rule on Y with GRID_H.
- CHECK edge (both compares use post-move positions):
  - Collision: head equals any segment i with 1 ≤ i < LENGTH → COLLISION ← 1, state ← DEAD.
  - Food (no collision): head equals (FOOD_X, FOOD_Y) → FOOD_EATEN high for exactly the following cycle; LENGTH ← min(LENGTH+1, MAX_LENGTH). The new segment is the old tail already stored.
  - Food and collision on the same step: collision wins; no FOOD_EATEN pulse; LENGTH unchanged.
  - LENGTH == MAX_LENGTH and food eaten: FOOD_EATEN still pulses; LENGTH holds.
- Latency: tick cycle T; positions updated at edge T+1; FOOD_EATEN/COLLISION visible from cycle T+2.
- Colour, combinational over pixel cell (ADDRH[9:2], ADDRV[8:2]). Priority, highest first:
  - head (segment 0): 12'hFF0; in DEAD: 12'hF0F
  - body (1 ≤ i < LENGTH): 12'h0F0
  - food: 12'hF00
  - background: 12'h000
  - Segments with i ≥ LENGTH are never drawn.

Decomposition:
- Shared package snake_pkg holds:
  - direction encodings UP/RIGHT/DOWN/LEFT and a reverse-of function
  - engine state encodings IDLE/RUN/MOVE/CHECK/DEAD
  - colour constants: head, dead-head, body, food, background
- Sub-module: existing Generic_counter, instantiated as the move tick timer (COUNTER_MAX = MOVE_PERIOD-1, reset = RESET or state ≠ RUN).
- Segment storage, collision compare and render stay in snake_engine.

Test Plan (MOVE_PERIOD=4, MAX_LENGTH=8, INIT_LENGTH=4, GRID 160×120 unless stated):
- Reset, ENABLE=1, NAV_STATE=RIGHT, 3 ticks → head (83,100), tail (80,100), LENGTH=4, COLLISION=0.
- Head at (159,50), RIGHT; one tick → head (0,50). Head at (10,0), UP; one tick → head (10,119).
- Moving RIGHT, NAV_STATE=LEFT; one tick → head X+1 (reversal ignored). Then NAV_STATE=UP → head Y-1.
- FOOD at (81,100), start RIGHT → FOOD_EATEN high exactly 1 cycle at T+2; LENGTH=5; new tail equals previous tail. Repeat to LENGTH=8, eat again → pulse, LENGTH stays 8.
- LENGTH=5, steer RIGHT,DOWN,LEFT,UP → collision on 4th step; COLLISION=1, state DEAD, head pixel 12'hF0F. Ticks and ENABLE toggles cause no movement. RESET restores reset state.
- ENABLE dropped for 20 cycles mid-run → positions frozen, no FOOD_EATEN. RESET asserted during the MOVE cycle → next cycle LENGTH=4, head (80,100), FOOD_EATEN=0.
